// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: round-robin arbiter for N_CH TDC channels feeding one
// shared readout path. A grant is held until the owner pulses its done bit,
// then hands over to the next eligible channel with no idle cycle between.
// Optional build macro RR_TIMEOUT_EN adds a watchdog that force-releases a
// grant after TIMEOUT_CYC busy cycles and pulses timeout_err.

// Per-channel eligibility and "above the pointer" flag for the rotating search.
module rr_arb_lane #(
  parameter int IDX_W = 3,
  parameter int IDX   = 0
) (
  input  logic             i_req,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_elig,
  output logic             o_hi
);
  assign o_elig = i_req & i_en;
  // Channels strictly above the last grant get first pick; the rest wrap.
  assign o_hi   = o_elig & (IDX_W'(IDX) > i_ptr);
endmodule

module rr_arbiter_param #(
  parameter int N_CH        = 8,
  parameter int IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  chan_en,
  input  logic [N_CH-1:0]  done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic             gnt_new,
  output logic             timeout_err
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic             r_new;
  logic [IDX_W-1:0] w_win;
  logic [N_CH-1:0]  w_elig;
  logic [N_CH-1:0]  w_hi;
  logic             w_any;
  logic             w_any_hi;
  logic             w_grant;
  logic             w_rel;
  logic             w_tmo;
  logic             w_done_cur;

  // Parameter sanity, caught at elaboration.
  if (N_CH < 1 || N_CH > 64) begin : g_bad_nch
    $error("rr_arbiter_param: N_CH must be 1..64");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_tmo
    $error("rr_arbiter_param: TIMEOUT_CYC must be >= 2");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    rr_arb_lane #(.IDX_W(IDX_W), .IDX(g)) u_lane (
      .i_req  (req[g]),
      .i_en   (chan_en[g]),
      .i_ptr  (r_ptr),
      .o_elig (w_elig[g]),
      .o_hi   (w_hi[g])
    );
  end

  assign w_any    = |w_elig;
  assign w_any_hi = |w_hi;

  // Lowest set bit above ptr wins; if none, lowest eligible overall (the wrap).
  // Indices only come from real lanes, so the winner is always < N_CH.
  always_comb begin
    w_win = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_any_hi ? w_hi[i] : w_elig[i]) w_win = IDX_W'(i);
    end
  end

  // Only the current owner's done bit counts; the rest are ignored.
  assign w_done_cur = done[r_idx];
  assign w_rel      = (r_state == S_BUSY) && (w_done_cur || w_tmo);

`ifdef RR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] r_wdog;
  logic            r_tmo;

  assign w_tmo       = (r_state == S_BUSY) && (r_wdog == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_err = r_tmo;

  // Watchdog: cleared by each new grant, counts busy cycles until release.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_tmo <= w_tmo & ~w_done_cur;
      if (w_grant)
        r_wdog <= '0;
      else if (r_state == S_BUSY && !w_rel)
        r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: grant from idle, or hand over / fall idle on release.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BUSY;
          w_grant     = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_rel) begin
          if (w_any) w_grant     = 1'b1;
          else       w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant index, rotation pointer and new-grant pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_idx <= '0;
      r_ptr <= IDX_W'(N_CH - 1);
      r_new <= 1'b0;
    end else begin
      r_new <= w_grant;
      if (w_grant) begin
        r_idx <= w_win;
        r_ptr <= w_win;
      end
    end
  end

  assign gnt_valid = (r_state == S_BUSY);
  assign gnt_idx   = r_idx;
  assign gnt_new   = r_new;

  // One-hot view of the grant, forced to zero while idle.
  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < N_CH; i++)
      gnt_onehot[i] = gnt_valid && (r_idx == IDX_W'(i));
  end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Bench for rr_arbiter_param: an 8-channel and a 5-channel instance, each
// tracked by a behavioural model checked every cycle, plus directed literals.
module tb_rr_arbiter_param;

  localparam int TCYC = 16;
`ifdef RR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] req_a, en_a, done_a;
  logic [4:0] req_b, en_b, done_b;

  logic       gnt_valid_a, gnt_new_a, timeout_err_a;
  logic [2:0] gnt_idx_a;
  logic [7:0] gnt_onehot_a;
  logic       gnt_valid_b, gnt_new_b, timeout_err_b;
  logic [2:0] gnt_idx_b;
  logic [4:0] gnt_onehot_b;

  int nchk = 0;
  int nerr = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_param #(.N_CH(8), .TIMEOUT_CYC(TCYC)) u_a (
    .clk(clk), .resetn(resetn), .req(req_a), .chan_en(en_a), .done(done_a),
    .gnt_valid(gnt_valid_a), .gnt_idx(gnt_idx_a), .gnt_onehot(gnt_onehot_a),
    .gnt_new(gnt_new_a), .timeout_err(timeout_err_a));

  rr_arbiter_param #(.N_CH(5), .TIMEOUT_CYC(TCYC)) u_b (
    .clk(clk), .resetn(resetn), .req(req_b), .chan_en(en_b), .done(done_b),
    .gnt_valid(gnt_valid_b), .gnt_idx(gnt_idx_b), .gnt_onehot(gnt_onehot_b),
    .gnt_new(gnt_new_b), .timeout_err(timeout_err_b));

  // Model state: grant held, owner, last winner, pulses, busy-cycle age.
  typedef struct {
    bit v; int idx; int ptr; bit nw; bit tmo; int age;
  } mst_t;

  mst_t ma, mb;

  function automatic mst_t mstep(mst_t s, int n, logic [7:0] rq, logic [7:0] en,
                                 logic [7:0] dn, bit rst);
    mst_t o;
    bit   rel, hit;
    int   w;
    o = s; o.nw = 0; o.tmo = 0; rel = 0; hit = 0;
    if (rst) begin
      o.v = 0; o.idx = 0; o.ptr = n - 1; o.age = 0;
      return o;
    end
    if (s.v) begin
      hit   = TMO_EN && (s.age == TCYC - 1);
      rel   = dn[s.idx] || hit;
      o.age = s.age + 1;
    end
    if (!s.v || rel) begin
      w = -1;
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (s.ptr + k) % n;
        if (w < 0 && rq[c] && en[c]) w = c;
      end
      if (w >= 0) begin
        o.v = 1; o.idx = w; o.ptr = w; o.nw = 1; o.age = 0;
      end else begin
        o.v = 0;
      end
      o.tmo = hit && !dn[s.idx];
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // Model advances on the same edge the DUT does, from the same inputs.
  always @(posedge clk) begin
    ma = mstep(ma, 8, req_a, en_a, done_a, !resetn);
    mb = mstep(mb, 5, {3'b0, req_b}, {3'b0, en_b}, {3'b0, done_b}, !resetn);
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("A.valid", gnt_valid_a, ma.v);
      chk("A.onehot", gnt_onehot_a, ma.v ? (1 << ma.idx) : 0);
      chk("A.new", gnt_new_a, ma.nw);
      chk("A.tmo", timeout_err_a, ma.tmo);
      if (ma.v) chk("A.idx", gnt_idx_a, ma.idx);
      chk("B.valid", gnt_valid_b, mb.v);
      chk("B.onehot", gnt_onehot_b, mb.v ? (1 << mb.idx) : 0);
      chk("B.new", gnt_new_b, mb.nw);
      chk("B.tmo", timeout_err_b, mb.tmo);
      if (mb.v) chk("B.idx", gnt_idx_b, mb.idx);
    end
  end

  initial begin
    int held;
    int exp_seq [3];
    ma = '{0, 0, 7, 0, 0, 0};
    mb = '{0, 0, 4, 0, 0, 0};
    resetn = 1'b0;
    req_a = 8'hFF; en_a = 8'hFF; done_a = 8'h00;
    req_b = 5'h00; en_b = 5'h1F; done_b = 5'h00;

    // Reset with all requests up: nothing granted.
    nx(); nx(); nx();
    cmp_on = 1'b1;
    chk("rst.valid", gnt_valid_a, 0);
    chk("rst.idx", gnt_idx_a, 0);
    chk("rst.onehot", gnt_onehot_a, 0);
    chk("rst.new", gnt_new_a, 0);
    chk("rst.tmo", timeout_err_a, 0);
    resetn = 1'b1;
    nx();
    chk("first.idx", gnt_idx_a, 0);
    chk("first.onehot", gnt_onehot_a, 8'h01);
    chk("first.new", gnt_new_a, 1);

    // Full rotation, done every third cycle, grants back to back.
    for (int g = 1; g <= 8; g++) begin
      int cur;
      cur = g - 1;
      nx(); nx();
      done_a = 8'(1 << cur);
      nx();
      done_a = 8'h00;
      chk("rr.idx", gnt_idx_a, g % 8);
      chk("rr.valid", gnt_valid_a, 1);
      chk("rr.new", gnt_new_a, 1);
    end

    // Move grant to 3; wrong-channel done ignored, then handover to 5.
    req_a = 8'h08; done_a = 8'h01; nx();
    chk("to3.idx", gnt_idx_a, 3);
    req_a = 8'h28; done_a = 8'h20; nx();
    chk("wrongdone.idx", gnt_idx_a, 3);
    chk("wrongdone.new", gnt_new_a, 0);
    done_a = 8'h08; nx();
    chk("rightdone.idx", gnt_idx_a, 5);
    done_a = 8'h00;

    // Enable mask: only 1 and 3 ever granted.
    req_a = 8'h0F; en_a = 8'h0A;
    exp_seq = '{1, 3, 1};
    for (int i = 0; i < 3; i++) begin
      done_a = 8'(1 << int'(gnt_idx_a)); nx(); done_a = 8'h00;
      chk("mask.idx", gnt_idx_a, exp_seq[i]);
    end
    req_a = 8'h00; en_a = 8'hFF; done_a = 8'h02; nx(); done_a = 8'h00;
    chk("idle.valid", gnt_valid_a, 0);
    chk("idle.onehot", gnt_onehot_a, 0);

    // Five channels: alternate 0,4,0; lone channel 4 re-granted to itself.
    req_b = 5'h11; nx();
    chk("n5.first", gnt_idx_b, 0);
    exp_seq = '{4, 0, 4};
    for (int i = 0; i < 3; i++) begin
      done_b = 5'(1 << int'(gnt_idx_b)); nx(); done_b = 5'h00;
      chk("n5.alt", gnt_idx_b, exp_seq[i]);
    end
    req_b = 5'h10; done_b = 5'h10; nx(); done_b = 5'h00;
    chk("n5.self.idx", gnt_idx_b, 4);
    chk("n5.self.new", gnt_new_b, 1);
    req_b = 5'h00; done_b = 5'h10; nx(); done_b = 5'h00;

    // Channel 2 granted with no done: watchdog handover to 7, or held.
    req_a = 8'h84; nx();
    chk("wd.start", gnt_idx_a, 2);
`ifdef RR_TIMEOUT_EN
    for (int i = 0; i < TCYC - 1; i++) begin
      nx();
      chk("wd.hold", gnt_idx_a, 2);
    end
    nx();
    chk("wd.err", timeout_err_a, 1);
    chk("wd.next", gnt_idx_a, 7);
    chk("wd.new", gnt_new_a, 1);
`else
    held = 1;
    for (int i = 0; i < 110; i++) begin
      nx();
      if (gnt_idx_a != 3'd2 || !gnt_valid_a || timeout_err_a) held = 0;
    end
    chk("hold.110", held, 1);
`endif
    req_a = 8'h00; done_a = 8'(1 << int'(gnt_idx_a)); nx(); done_a = 8'h00;

    // Random traffic, with quiet windows and the occasional reset.
    for (int c = 0; c < 3000; c++) begin
      bit quiet;
      quiet  = (c % 200) >= 160;
      resetn = ($urandom_range(0, 299) != 0);
      req_a  = 8'($urandom) | 8'($urandom);
      en_a   = 8'($urandom) | 8'($urandom) | 8'($urandom);
      req_b  = 5'($urandom);
      en_b   = 5'($urandom) | 5'($urandom);
      done_a = 8'($urandom) & 8'($urandom) & 8'($urandom);
      done_b = 5'($urandom) & 5'($urandom) & 5'($urandom);
      if ($urandom_range(0, 3) == 0) done_a = done_a | 8'(1 << ma.idx);
      if ($urandom_range(0, 3) == 0) done_b = done_b | 5'(1 << mb.idx);
      if (quiet) begin
        done_a = done_a & ~8'(1 << ma.idx);
        done_b = done_b & ~5'(1 << mb.idx);
      end
      nx();
    end

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised round-robin arbiter granting one of N_CH TDC channels access to a shared resource (readout FIFO or encoder).
- Generalises the fixed 8-channel arbiter in four ways: configurable channel count, runtime channel-enable mask, one-hot and binary grant outputs, and zero-bubble back-to-back grants.
- A grant is held until the granted channel signals done. It sits between the per-channel TDC hit buffers and the shared readout path.

Parameters:
- N_CH, 8, number of requesting channels; legal range 1..64, power of two not required.
- IDX_W, $clog2(N_CH) with a minimum of 1, width of the binary grant index.
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles; used only with RR_TIMEOUT_EN; must be >= 2.

Ports:
- clk, input, 1, clock.
- resetn, input, 1, synchronous active-low reset.
- req, input, N_CH, per-channel request level.
- chan_en, input, N_CH, per-channel enable mask; an eligible request is req & chan_en.
- done, input, N_CH, per-channel release pulse; only the bit of the granted channel is honoured.
- gnt_valid, output, 1, a grant is active.
- gnt_idx, output, IDX_W, binary index of the granted channel.
- gnt_onehot, output, N_CH, one-hot grant; all zeros when gnt_valid is 0.
- gnt_new, output, 1, one-cycle pulse on the first cycle of every new grant.
- timeout_err, output, 1, one-cycle pulse on watchdog release; constant 0 without RR_TIMEOUT_EN.

Behaviour:
- Reset (resetn = 0 at a clk edge):
  - state = IDLE, gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0, gnt_new = 0, timeout_err = 0.
  - ptr (last-granted index) = N_CH-1, so channel 0 has highest priority after reset.
  - Reset mid-grant drops the grant immediately; no done is required.
- Arbitration function:
  - Search the eligible vector starting at ptr+1 and wrapping modulo N_CH, ending at ptr itself; the first set bit wins.
  - gnt_idx is never >= N_CH; this includes non-power-of-two N_CH.
- IDLE state:
  - If any bit of req & chan_en is set in cycle t, then at cycle t+1: state = BUSY, gnt_valid = 1, gnt_idx/gnt_onehot = winner, gnt_new = 1, ptr = winner.
  - Latency from request to grant is exactly 1 cycle.
- BUSY state: the grant is held regardless of changes to req or chan_en.
  - If done[gnt_idx] = 1 in cycle t, re-arbitrate using the req & chan_en values of cycle t.
  - Winner exists: at t+1 the grant switches directly to the winner, gnt_valid stays 1, gnt_new = 1. This is back-to-back with no bubble.
  - The releasing channel can win again only if no other channel is eligible.
  - No winner: at t+1 state = IDLE and gnt_valid = 0.
- done bits of non-granted channels are ignored in every state.
- N_CH = 1: channel 0 is granted repeatedly; gnt_idx is always 0.

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- With the macro: a watchdog counter clears on every new grant and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYC-1 without done, the grant is released exactly as if done[gnt_idx] had been asserted, and timeout_err pulses 1 on the same cycle the new grant or IDLE takes effect.
  - The counter is reset by resetn.
- Without the macro: no counter is built, timeout_err is tied to 0, and a grant is held indefinitely until done.

Test Plan:
- Reset with req = 8'hFF held -> gnt_valid = 0 during reset. First cycle after reset: gnt_idx = 0, gnt_onehot = 8'h01, gnt_new = 1.
- req = 8'hFF, chan_en = 8'hFF, done[gnt_idx] pulsed every 3rd cycle -> gnt_idx sequence 0,1,2,...,7,0; no gap cycles between grants.
- Channel 3 granted, req = 8'h28, done = 8'h20 (wrong channel) -> grant stays 3. Then done = 8'h08 -> next cycle gnt_idx = 5.
- req = 8'h0F, chan_en = 8'h0A -> only channels 1 and 3 are ever granted, alternating 1,3,1.
- N_CH = 5, req = 5'h11, repeated done -> gnt_idx alternates 0,4,0. Single req on channel 4 with ptr = 4 -> re-granted 4, never index 5..7.
- RR_TIMEOUT_EN, TIMEOUT_CYC = 16, channel 2 granted, no done, req = 8'h84 -> after 16 BUSY cycles timeout_err = 1 and gnt_idx = 7. Without the macro, grant 2 held for 100+ cycles.
